// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int          BCD_DIGITS = 3;
    localparam int          BCD_W      = 12;
    localparam logic [3:0]  ADJ_THRESH = 4'd5;
    localparam logic [3:0]  ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: a digit of 5 or more gets 3 added so
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add-3 correction, purely combinational.
    always_comb begin
        dout = din;
        if (din >= ADJ_THRESH) begin
            dout = din + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift per clock (double dabble).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; BIN is captured when start is seen
// CONV  | one add-3/shift step per edge; last step loads BCD and pulses done
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     BIN,
    output logic [BCD_W-1:0] BCD,
    output logic             busy,
    output logic             done
);

    localparam int         SR_W     = BCD_W + W;
    localparam logic [3:0] LAST_CNT = 4'(W - 1);

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              done_q, done_d;

    logic [BCD_W-1:0]  dig_adj;
    logic [SR_W-1:0]   sr_pre;
    logic [SR_W-1:0]   sr_shift;

    // Correct every digit field of the working register before the shift.
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (sr_q[W + 4*g +: 4]),
            .dout (dig_adj[4*g +: 4])
        );
    end

    // Corrected digits above the untouched binary bits, then shift left by one.
    // The hundreds MSB falls off; it is always zero for W <= 9.
    always_comb begin
        sr_pre   = {dig_adj, sr_q[W-1:0]};
        sr_shift = sr_pre << 1;
    end

    // Next-state, datapath and output decisions.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {{BCD_W{1'b0}}, BIN};
                    cnt_d   = 4'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    bcd_d   = sr_shift[SR_W-1:W];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, working register, counter and output registers; reset drops any
    // conversion in flight without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= 4'd0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign BCD  = bcd_q;
    assign done = done_q;
    assign busy = (state_q == CONV);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq (W = 8).
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bin_r = 8'd0;
    logic [11:0] bcd;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .BIN   (bin_r),
        .BCD   (bcd),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Start one conversion and follow it to done (bounded). BIN is scrambled
    // right after acceptance, which must not affect the result.
    task automatic run_conv(input logic [7:0] v, output int edges,
                            output int busy_cnt, output bit stable);
        logic [11:0] prev;
        prev     = bcd;
        start    = 1'b1;
        bin_r    = v;
        tick();
        start    = 1'b0;
        bin_r    = ~v;
        busy_cnt = busy ? 1 : 0;
        edges    = 0;
        stable   = 1'b1;
        while (!done && edges < 20) begin
            tick();
            edges++;
            if (!done) begin
                if (busy) busy_cnt++;
                if (bcd !== prev) stable = 1'b0;
            end
        end
    endtask

    initial begin
        int  edges;
        int  bcnt;
        bit  stable;
        int  dcount;
        logic ok;

        // reset state
        #2;
        check("rst_bcd", bcd, 12'h000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        tick();
        rst = 1'b0;

        // zero operand, timing and busy width
        run_conv(8'd0, edges, bcnt, stable);
        check("zero_latency", edges, 8);
        check("zero_bcd", bcd, 12'h000);
        check("zero_busy_cycles", bcnt, 8);
        check("zero_busy_at_done", busy, 1'b0);
        tick();
        check("zero_done_one_cycle", done, 1'b0);

        run_conv(8'd255, edges, bcnt, stable);
        check("255_latency", edges, 8);
        check("255_bcd", bcd, 12'h255);

        run_conv(8'd99, edges, bcnt, stable);
        check("99_bcd", bcd, 12'h099);
        check("99_bcd_stable_during_conv", stable, 1'b1);

        run_conv(8'd100, edges, bcnt, stable);
        check("100_bcd", bcd, 12'h100);
        tick();

        // start held high, BIN changed mid-conversion
        start  = 1'b1;
        bin_r  = 8'd42;
        tick();                       // E0
        dcount = 0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 2) bin_r = 8'd7;
            tick();
            if (done) begin
                dcount++;
                if (i == 8) check("held_first_bcd", bcd, 12'h042);
                else        check("held_unexpected_done_edge", i, 8);
            end
        end
        check("held_done_count", dcount, 1);
        check("held_bcd_kept", bcd, 12'h042);
        tick();                       // E17 of the window: second conversion ends
        start = 1'b0;
        check("held_second_done", done, 1'b1);
        check("held_second_bcd", bcd, 12'h007);
        tick();

        // reset in the middle of a conversion of 200
        start = 1'b1;
        bin_r = 8'd200;
        tick();                       // E0
        start = 1'b0;
        tick(); tick(); tick();       // E1..E3
        @(posedge clk);               // E4
        #1;
        rst = 1'b1;
        #1;
        check("abort_bcd", bcd, 12'h000);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) dcount++;
        end
        check("abort_no_done_after", dcount, 0);
        // start on the first edge after reset release
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_conv(8'd13, edges, bcnt, stable);
        check("post_rst_latency", edges, 8);
        check("post_rst_bcd", bcd, 12'h013);

        // back-to-back: start asserted in the done cycle
        tick();
        run_conv(8'd128, edges, bcnt, stable);
        check("b2b_first_bcd", bcd, 12'h128);
        start = 1'b1;
        bin_r = 8'd64;
        edges = 0;
        tick();
        edges++;
        start = 1'b0;
        bin_r = 8'd0;
        while (!done && edges < 20) begin
            tick();
            edges++;
        end
        check("b2b_done_spacing", edges, 9);
        check("b2b_second_bcd", bcd, 12'h064);
        tick();

        // exhaustive sweep against the decimal model
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), edges, bcnt, stable);
            ok = (bcd[11:8] <= 4'd9) && (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
            check($sformatf("sweep_%0d_bcd", v), bcd, ref_bcd(v));
            check($sformatf("sweep_%0d_digits_le9", v), ok, 1'b1);
            check($sformatf("sweep_%0d_latency", v), edges, 8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter W, default 8: binary input width; legal range 4..9, since the result must fit 3 BCD digits.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: conversion request, sampled on the rising clk edge.
REQ-005 SHALL have port BIN, input, W: unsigned binary operand, captured only when a start is accepted.
REQ-006 SHALL have port BCD, output, 12: registered result; {hundreds[11:8], tens[7:4], units[3:0]}.
REQ-007 SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-009 SHALL implement a two-state FSM, IDLE and CONV, using shift-add-3 (double dabble).
REQ-010 SHALL accept start only in IDLE; acceptance edge E0 loads the shift register with {12'b0, BIN}, clears the bit counter and enters CONV.
REQ-011 SHALL ignore start while in CONV; BIN changes after E0 SHALL NOT affect the result.
REQ-012 SHALL, on each CONV edge, first add 3 to every BCD digit field whose value is >=5, then shift the whole {digits, binary} register left by 1.
REQ-013 SHALL perform exactly W shifts, at edges E1..EW.
REQ-014 SHALL, at edge EW, load BCD with the final digit fields, set done=1, clear busy and return to IDLE.
REQ-015 SHALL hold done high for exactly one cycle, between EW and EW+1.
REQ-016 SHALL drive busy high from E0 through EW, i.e. during the W cycles following acceptance.
REQ-017 SHALL keep BCD stable between completions and update it only at EW.
REQ-018 SHALL accept a start asserted in the done cycle (FSM already IDLE), giving back-to-back conversions with W+1 edges of start-to-start spacing.
REQ-019 SHALL produce, for every legal input, digit fields that are each in the range 0..9 and that equal the decimal value of BIN.
REQ-020 SHALL implement the bit counter as 4 bits and compare it against W-1 to detect the last shift.

Reset
REQ-021 SHALL, on rst=1 at any time including mid-conversion, immediately force IDLE, BCD=12'h000, busy=0, done=0, clear the shift register and clear the counter.
REQ-022 SHALL discard any conversion aborted by reset, with no done pulse emitted.
REQ-023 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-024 SHALL place the following in shared package bcd_pkg:
- FSM state typedef (IDLE, CONV);
- constant BCD_DIGITS=3;
- constant BCD_W=12;
- constant ADJ_THRESH=5;
- constant ADJ_ADD=3.
REQ-025 SHALL instantiate sub-module bcd_digit_adj (4-bit in, 4-bit out, combinational: add 3 if >=5) once per digit, three instances.
REQ-026 SHALL contain all sequential logic (FSM, counter, shift register, output registers) in bin_to_bcd_seq.

Verification
REQ-027 SHALL verify: BIN=8'd0, start pulse -> done 8 edges after E0, BCD=12'h000, busy high for 8 cycles.
REQ-028 SHALL verify: BIN=8'd255 -> BCD=12'h255 at done; BIN=8'd99 -> BCD=12'h099; BIN=8'd100 -> BCD=12'h100.
REQ-029 SHALL verify: start held high continuously with BIN changed mid-conversion from 8'd42 to 8'd7 -> first result 12'h042, ignored starts produce no extra done pulses, next result reflects BIN sampled at the next IDLE acceptance.
REQ-030 SHALL verify: rst asserted at E4 of a conversion of 8'd200 -> outputs zero immediately, no done pulse; a new start with 8'd13 after release -> BCD=12'h013.
REQ-031 SHALL verify: start asserted in the done cycle with 8'd128 then 8'd64 -> two done pulses 9 edges apart, BCD=12'h128 then 12'h064.
REQ-032 SHALL verify: exhaustive sweep of BIN 0..255 against a decimal reference model, with every digit field <=9.
